relu_frame_sched: RTL and testbench

- Sequences one feature map of R*C signed pixels through the ReLU activation stage.
- Generates read addresses into the feature buffer and applies ReLU (negative -> 0) to each returned pixel.
- Emits results on a valid/ready stream tagged with the pixel address, and counts the clipped pixels.
- Sits between the conv output buffer and the pooling/next-layer input. Replaces the fully parallel R*C-lane activation with one lane that is time-multiplexed.

---
 rtl/relu_frame_sched.sv | 157 +++++++++++++++
 tb/tb_relu_frame_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_frame_sched.sv
// relu_frame_sched: walks one R x C feature map through a single ReLU lane.
// Reads are issued row-major, each returned pixel is clipped at zero, and the
// result leaves on a valid/ready stream tagged with its address. A two-entry
// buffer (output register + skid register) absorbs downstream stalls.
module relu_frame_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int R          = 3,
    parameter int C          = 3,
    parameter int AW         = (R * C > 1) ? $clog2(R * C) : 1,
    parameter int CW         = $clog2(R * C + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [AW-1:0]         out_addr,
    output logic [CW-1:0]         neg_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(R * C - 1);

    state_t                  state;
    state_t                  state_nx;
    logic                    pend;
    logic [AW-1:0]           pend_addr;
    logic                    skid_valid;
    logic [DATA_WIDTH-1:0]   skid_data;
    logic [AW-1:0]           skid_addr;
    logic                    xfer;
    logic [1:0]              occ;
    logic                    is_neg;
    logic [DATA_WIDTH-1:0]   relu_val;
    logic                    frame_start;

    // ReLU of the pixel returning this cycle, occupancy and handshake
    always_comb begin
        is_neg      = rd_data[DATA_WIDTH-1];
        relu_val    = is_neg ? '0 : rd_data;
        xfer        = out_valid & out_ready;
        // An output entry leaving this cycle frees its slot for a new read,
        // which keeps one pixel per cycle with out_ready held high.
        occ         = 2'(pend) + 2'(skid_valid) + 2'(out_valid & ~out_ready);
        frame_start = (state == S_IDLE) && start;
    end

    // Next-state logic and control outputs
    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        rd_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                rd_en = (occ < 2'd2);
                if (rd_en && (rd_addr == LAST_ADDR)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (xfer && (out_addr == LAST_ADDR)) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Read address counter; parks at the last address rather than wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (frame_start) begin
            rd_addr <= '0;
        end else if (rd_en && (rd_addr != LAST_ADDR)) begin
            rd_addr <= rd_addr + AW'(1);
        end
    end

    // Track the read in flight and the address it belongs to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_addr <= '0;
        end else begin
            pend      <= rd_en;
            pend_addr <= rd_addr;
        end
    end

    // Count clipped pixels as their results are produced
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_count <= '0;
        end else if (frame_start) begin
            neg_count <= '0;
        end else if (pend && is_neg) begin
            neg_count <= neg_count + CW'(1);
        end
    end

    // Output register plus skid register, preserving address order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_addr  <= '0;
        end else if (!out_valid || xfer) begin
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_addr  <= skid_addr;
                if (pend) begin
                    skid_data <= relu_val;
                    skid_addr <= pend_addr;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else begin
                out_valid <= pend;
                if (pend) begin
                    out_data <= relu_val;
                    out_addr <= pend_addr;
                end
            end
        end else if (pend) begin
            skid_valid <= 1'b1;
            skid_data  <= relu_val;
            skid_addr  <= pend_addr;
        end
    end

endmodule

// File: tb/tb_relu_frame_sched.sv
// Directed bench for relu_frame_sched: a 3x3 instance exercised with steady
// and stalling out_ready, ignored starts, back-to-back frames and mid-frame
// reset, plus a 1x1 instance for the degenerate frame.
module tb_relu_frame_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start1;

    logic        busy, done, rd_en, out_valid, out_ready;
    logic [3:0]  rd_addr, out_addr, neg_count;
    logic [31:0] rd_data, out_data;

    logic        busy1, done1, rd_en1, out_valid1, out_ready1;
    logic [0:0]  rd_addr1, out_addr1, neg_count1;
    logic [31:0] rd_data1, out_data1;

    relu_frame_sched #(.DATA_WIDTH(32), .R(3), .C(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .neg_count(neg_count)
    );

    relu_frame_sched #(.DATA_WIDTH(32), .R(1), .C(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_addr(out_addr1), .neg_count(neg_count1)
    );

    logic [31:0] mem   [0:15];
    logic [31:0] exp_d [0:8];

    // Feature buffer models: data returns one cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en1) rd_data1 <= 32'hFFFF_FFFD;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int n_xfer, issued, ndone, done_cyc, first_v, last_x, max_out, negc_c1;

    // Runs one frame on the 3x3 instance; cycle 0 is the cycle start is driven.
    task automatic run_frame(input int mode, input logic [31:0] start_mask, input int abort_at);
        logic [15:0] rpat;
        logic        stall_prev;
        logic [31:0] pd;
        logic [3:0]  pa;
        int          outst;
        rpat = 16'b1011_0010_1101_0011;
        n_xfer = 0; issued = 0; ndone = 0; done_cyc = -1; first_v = -1;
        last_x = -1; max_out = 0; negc_c1 = -1;
        stall_prev = 1'b0; pd = '0; pa = '0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            start     = (cyc < 32) ? start_mask[cyc] : 1'b0;
            out_ready = (mode == 0) ? 1'b1 : rpat[cyc % 16];
            #1;
            if (cyc == 1) negc_c1 = int'(neg_count);
            outst = issued - n_xfer;
            if (outst > max_out) max_out = outst;
            if (stall_prev) begin
                chk("hold_data", out_data, pd);
                chk("hold_addr", out_addr, pa);
            end
            if (rd_en) begin
                chk("rd_addr", rd_addr, issued);
                issued++;
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("idle_after_done", busy, 0);
                break;
            end
            stall_prev = out_valid && !out_ready;
            pd = out_data;
            pa = out_addr;
            if (out_valid && out_ready) begin
                if (n_xfer < 9) begin
                    chk("out_data", out_data, exp_d[n_xfer]);
                    chk("out_addr", out_addr, n_xfer);
                end else begin
                    chk("extra_xfer", n_xfer, 8);
                end
                n_xfer++;
                last_x = cyc;
                if (n_xfer == abort_at) break;
            end
        end
        if (abort_at == 0) chk("frame_done_seen", done_cyc >= 0, 1);
    endtask

    initial begin
        int cnt1, dc1;
        mem[0] = 32'd5;         mem[1] = 32'hFFFF_FFFF; mem[2] = 32'd0;
        mem[3] = 32'd7;         mem[4] = 32'hFFFF_FF80; mem[5] = 32'h7FFF_FFFF;
        mem[6] = 32'hFFFF_FFFE; mem[7] = 32'd1;         mem[8] = 32'h8000_0000;
        for (int i = 9; i < 16; i++) mem[i] = '0;
        exp_d[0] = 32'd5; exp_d[1] = 32'd0; exp_d[2] = 32'd0;
        exp_d[3] = 32'd7; exp_d[4] = 32'd0; exp_d[5] = 32'h7FFF_FFFF;
        exp_d[6] = 32'd0; exp_d[7] = 32'd1; exp_d[8] = 32'd0;

        // Reset held with start asserted
        rst_n = 1'b0; start = 1'b1; start1 = 1'b1; out_ready = 1'b0; out_ready1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
            chk("rst_rd_en", rd_en, 0);     chk("rst_out_valid", out_valid, 0);
            chk("rst_rd_addr", rd_addr, 0); chk("rst_out_data", out_data, 0);
            chk("rst_out_addr", out_addr, 0); chk("rst_neg", neg_count, 0);
            chk("rst1_busy", busy1, 0);     chk("rst1_rd_en", rd_en1, 0);
        end
        start = 1'b0; start1 = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_rd", rd_en, 0);

        // Frame A: steady out_ready
        run_frame(0, 32'd0, 0);
        chk("A_first_valid", first_v, 3);
        chk("A_last_xfer", last_x, 11);
        chk("A_done_cyc", done_cyc, 12);
        chk("A_ndone", ndone, 1);
        chk("A_nxfer", n_xfer, 9);
        chk("A_neg", neg_count, 4);
        chk("A_max_out", max_out <= 2, 1);

        // Frame B: start pulses in cycle 4 and in the done cycle are ignored
        run_frame(0, (32'd1 << 4) | (32'd1 << 12), 0);
        chk("B_nxfer", n_xfer, 9);
        chk("B_ndone", ndone, 1);
        chk("B_done_cyc", done_cyc, 12);

        // Frame C: back-to-back start, stalling out_ready
        run_frame(1, 32'd0, 0);
        chk("C_neg_cleared", negc_c1, 0);
        chk("C_nxfer", n_xfer, 9);
        chk("C_ndone", ndone, 1);
        chk("C_done_after_last", done_cyc, last_x + 1);
        chk("C_max_out", max_out <= 2, 1);
        chk("C_neg", neg_count, 4);

        // Frame D: reset after the fourth transfer
        run_frame(0, 32'd0, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("D_ndone", ndone, 0);
        chk("D_busy", busy, 0);         chk("D_done", done, 0);
        chk("D_rd_en", rd_en, 0);       chk("D_out_valid", out_valid, 0);
        chk("D_rd_addr", rd_addr, 0);   chk("D_out_data", out_data, 0);
        chk("D_out_addr", out_addr, 0); chk("D_neg", neg_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame E: fresh frame after abort restarts at address 0
        run_frame(0, 32'd0, 0);
        chk("E_nxfer", n_xfer, 9);
        chk("E_done_cyc", done_cyc, 12);
        chk("E_neg", neg_count, 4);

        // Degenerate 1x1 frame
        cnt1 = 0; dc1 = -1;
        start1 = 1'b1; out_ready1 = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            #1;
            if (out_valid1 && out_ready1) begin
                chk("one_data", out_data1, 0);
                chk("one_addr", out_addr1, 0);
                cnt1++;
            end
            if (done1) begin
                dc1 = cyc;
                break;
            end
        end
        chk("one_done_cyc", dc1, 4);
        chk("one_neg", neg_count1, 1);
        chk("one_count", cnt1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
